// File: rtl/tpu_apb_master.sv
// tpu_apb_master: command/response front end driving a single APB requester port.
// A command is a plain read, a plain write, or a poll. A poll re-reads one
// register until (PRDATA & mask) == (expect & mask) or POLL_MAX reads are used.
// Optional feature: define TPU_APB_MASTER_TIMEOUT_EN to abort an access that
// has been stalled by PREADY=0 for TIMEOUT_CYCLES consecutive ACCESS cycles.
module tpu_apb_master #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 32,
  parameter int POLL_MAX       = 255,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic              cmd_poll,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [DATA_W-1:0] cmd_mask,
  input  logic [DATA_W-1:0] cmd_expect,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic [7:0]        rsp_polls,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PWRITE,
  output logic              PSEL,
  output logic              PENABLE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam int CNT_W = $clog2(POLL_MAX + 1);

  // A zero poll budget or zero timeout would make the machine meaningless.
  if (POLL_MAX < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("tpu_apb_master: POLL_MAX and TIMEOUT_CYCLES must both be at least 1");
  end

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mask_q;
  logic [DATA_W-1:0] expect_q;
  logic              write_q;
  logic              poll_q;
  logic [CNT_W-1:0]  poll_cnt;
  logic [CNT_W:0]    cnt_next;
  logic [7:0]        polls_sat;
  logic              matched;
  logic              exhausted;
  logic              timeout_hit;
  logic [DATA_W-1:0] rdata_q;
  logic              error_q;
  logic [7:0]        polls_q;

  assign cnt_next  = {1'b0, poll_cnt} + (CNT_W+1)'(1);
  assign exhausted = (cnt_next >= (CNT_W+1)'(POLL_MAX));
  assign matched   = ((PRDATA & mask_q) == (expect_q & mask_q));

  // Reported read count saturates at 255 even if POLL_MAX is larger.
  always_comb begin
    polls_sat = 8'(cnt_next);
    if (int'(cnt_next) > 255) polls_sat = 8'hFF;
  end

`ifdef TPU_APB_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;

  // Count consecutive stalled ACCESS cycles; every new SETUP starts a fresh count.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (next_state == SETUP) begin
      to_cnt <= '0;
    end else if (state == ACCESS && !PREADY) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  assign timeout_hit = (state == ACCESS) && !PREADY &&
                       (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state decision: polls loop back to SETUP until match or budget spent.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (cmd_valid) next_state = SETUP;
      end
      SETUP: begin
        next_state = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          if (write_q || !poll_q || matched || exhausted) next_state = RESP;
          else                                            next_state = SETUP;
        end else if (timeout_hit) begin
          next_state = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // APB and handshake outputs are pure decodes of the state and latched command.
  always_comb begin
    cmd_ready = (state == IDLE) && !reset;
    rsp_valid = (state == RESP);
    PSEL      = (state == SETUP) || (state == ACCESS);
    PENABLE   = (state == ACCESS);
    PADDR     = addr_q;
    PWRITE    = write_q;
    PWDATA    = wdata_q;
    rsp_rdata = rdata_q;
    rsp_error = error_q;
    rsp_polls = polls_q;
  end

  // State register, command latch and response capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      mask_q   <= '0;
      expect_q <= '0;
      write_q  <= 1'b0;
      poll_q   <= 1'b0;
      poll_cnt <= '0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
      polls_q  <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && cmd_valid) begin
        addr_q   <= cmd_addr;
        wdata_q  <= cmd_wdata;
        mask_q   <= cmd_mask;
        expect_q <= cmd_expect;
        write_q  <= cmd_write;
        poll_q   <= cmd_poll && !cmd_write;
        poll_cnt <= '0;
        rdata_q  <= '0;
        error_q  <= 1'b0;
        polls_q  <= '0;
      end else if (state == ACCESS && PREADY) begin
        if (write_q) begin
          rdata_q <= '0;
          error_q <= 1'b0;
          polls_q <= '0;
        end else begin
          rdata_q  <= PRDATA;
          poll_cnt <= cnt_next[CNT_W-1:0];
          polls_q  <= polls_sat;
          error_q  <= poll_q && !matched && exhausted;
        end
      end else if (timeout_hit) begin
        rdata_q <= '0;
        error_q <= 1'b1;
      end
    end
  end

endmodule

// File: doc/tpu_apb_master.md
TPU_APB_MASTER -- requirements
Module: tpu_apb_master

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high; the ports SHALL be named clk and reset.
REQ-002 The block SHALL provide these parameters (name, default, meaning):
- ADDR_W, 8, APB address width.
- DATA_W, 32, APB data width.
- POLL_MAX, 255, maximum number of poll reads per poll command (minimum 1).
- TIMEOUT_CYCLES, 1024, wait-state limit per access.

REQ-003 The block SHALL provide these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- cmd_valid, in, 1, command offered.
- cmd_ready, out, 1, command accepted when high together with cmd_valid.
- cmd_write, in, 1, 1 = write, 0 = read.
- cmd_poll, in, 1, repeat read until the read data matches (read only).
- cmd_addr, in, ADDR_W, register address.
- cmd_wdata, in, DATA_W, write data.
- cmd_mask, in, DATA_W, poll compare mask.
- cmd_expect, in, DATA_W, poll compare value.
- rsp_valid, out, 1, response available.
- rsp_ready, in, 1, response consumed.
- rsp_rdata, out, DATA_W, last read data (0 for writes).
- rsp_error, out, 1, command failed (timeout or poll limit exhausted).
- rsp_polls, out, 8, number of reads issued (0 for writes).
- PADDR, out, ADDR_W, APB address.
- PWRITE, out, 1, APB direction.
- PSEL, out, 1, APB select.
- PENABLE, out, 1, APB enable.
- PWDATA, out, DATA_W, APB write data.
- PRDATA, in, DATA_W, APB read data.
- PREADY, in, 1, APB ready.

Function
REQ-004 The state machine SHALL have the states IDLE, SETUP, ACCESS and RESP.
REQ-005 cmd_ready SHALL be 1 only in IDLE; a command accepted in IDLE SHALL latch addr, wdata, write, poll, mask and expect, and the next state SHALL be SETUP.
REQ-006 SETUP SHALL drive PSEL=1 and PENABLE=0 with PADDR/PWRITE/PWDATA from the latched command, and SHALL always go to ACCESS after one cycle.
REQ-007 ACCESS SHALL drive PSEL=1 and PENABLE=1 and SHALL hold until PREADY=1; PADDR, PWRITE and PWDATA SHALL stay stable from SETUP through the end of ACCESS.
REQ-008 On PREADY=1 with a write, the block SHALL go to RESP with rsp_rdata=0, rsp_error=0 and rsp_polls=0.
REQ-009 On PREADY=1 with a read, the block SHALL capture PRDATA into rsp_rdata and increment the poll count.
REQ-010 For a non-poll read, the block SHALL go to RESP after the capture.
REQ-011 For a poll read with (PRDATA & mask)==(expect & mask), the block SHALL go to RESP with rsp_error=0.
REQ-012 For a poll read with no match and count<POLL_MAX, the block SHALL return to SETUP next cycle with PSEL held at 1 and PENABLE at 0.
REQ-013 For a poll read with no match and count==POLL_MAX, the block SHALL go to RESP with rsp_error=1.
REQ-014 A poll command with cmd_write=1 SHALL be executed as a plain write, and cmd_poll SHALL be ignored.
REQ-015 RESP SHALL drive PSEL=0, PENABLE=0 and rsp_valid=1, and SHALL hold the response fields until rsp_ready=1; the next state SHALL then be IDLE.
REQ-016 Minimum cost SHALL be: write 4 cycles from acceptance to rsp_valid with zero wait states; each additional poll read SHALL add 2 cycles plus wait states.
REQ-017 PSEL and PENABLE SHALL be 0 in IDLE and RESP.
REQ-018 rsp_valid SHALL be 0 outside RESP.
REQ-019 rsp_polls SHALL saturate at 255.

Reset
REQ-020 When reset=1 at a clock edge, the state SHALL become IDLE and all outputs SHALL be 0, except cmd_ready, which SHALL be 1 from the first cycle after reset deasserts.
REQ-021 Reset during SETUP, ACCESS or RESP SHALL abandon the transfer, with no response produced; PSEL/PENABLE SHALL be 0 on the cycle after the reset edge.

Configuration
REQ-022 With TPU_APB_MASTER_TIMEOUT_EN defined, a counter SHALL count consecutive ACCESS cycles with PREADY=0.
REQ-023 With TPU_APB_MASTER_TIMEOUT_EN defined, when that count reaches TIMEOUT_CYCLES the block SHALL go to RESP with rsp_error=1 and rsp_rdata=0, abort any remaining polls, and drop PSEL/PENABLE.
REQ-024 The timeout counter SHALL clear on every entry to SETUP.
REQ-025 With TPU_APB_MASTER_TIMEOUT_EN undefined, ACCESS SHALL wait indefinitely, and rsp_error SHALL arise only from poll exhaustion.

Verification
REQ-026 Write addr 0x04 data 0xDEADBEEF, PREADY tied 1 -> one SETUP and one ACCESS cycle, PWDATA=0xDEADBEEF; rsp_valid 4 cycles after acceptance with error=0, polls=0.
REQ-027 Read addr 0x08, PREADY low 3 cycles and PRDATA=0x12345678 -> ACCESS lasts 4 cycles with PADDR stable; rsp_rdata=0x12345678, polls=1.
REQ-028 Poll addr 0x00 mask 0x1 expect 0x1, PRDATA bit0 set on the 5th read -> 5 SETUP/ACCESS pairs; rsp_polls=5, error=0.
REQ-029 Poll with PRDATA never matching and POLL_MAX=3 -> exactly 3 reads; rsp_error=1, rsp_polls=3.
REQ-030 Macro defined, TIMEOUT_CYCLES=16, PREADY held 0 -> rsp_error=1 after 16 ACCESS cycles; macro undefined -> no response after 100 cycles.
REQ-031 Reset asserted mid-ACCESS, then rsp_ready held 0 -> PSEL=0 the next cycle, no rsp_valid, cmd_ready=1 after reset deasserts.
